// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read arbiter: default geometry and
// the fixed request-to-ack pipeline latency.
package regfile_read_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int PIPE_LAT = 2;

  // Width of a requester index; at least one bit so a single requester still works.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so ptr + k can be wrapped without overflow.
      cand = {1'b0, ptr} + k[PW:0];
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && eligible[cand[PW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[PW-1:0]]   = 1'b1;
        idx                   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates NREQ requesters onto one register-file read port: stage 1 grants
// round-robin, stage 2 captures rd_data (with same-cycle write forwarding).
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  localparam int PW  = ptr_w(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [AW-1:0]      rd_sel,
  input  logic [DW-1:0]      rd_data,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [PW-1:0]      dbg_ptr
);

  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [AW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic [AW-1:0]   win_addr;

  // A requester is masked while its read is in either stage, so it is never
  // granted twice for one request.
  assign eligible = req & ~gnt_q & ~ack_q;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick_grant),
    .idx      (pick_idx)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) win_addr = win_addr | addr[i*AW +: AW];
    end

    gnt_d = pick_grant;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (|pick_grant) begin
      sel_d = win_addr;
      ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
    end

    ack_d   = gnt_q;
    rdata_d = rdata_q;
    if (|gnt_q) begin
      // A write landing in the read cycle wins over the stale mux output.
      rdata_d = (wr_en && (wr_addr == sel_q)) ? wr_data : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      ack_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rd_sel  = sel_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign busy    = (|gnt_q) | (|ack_q);
  assign dbg_ptr = ptr_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: a behavioural register file
// drives rd_data, and expected acks are queued when requests are driven.
module tb_regfile_read_arbiter;
  import regfile_read_arbiter_pkg::*;

  localparam int NREQ = NREQ_DEF;
  localparam int AW   = AW_DEF;
  localparam int DW   = DW_DEF;
  localparam int PW   = ptr_w(NREQ);
  localparam int W    = 16 + NREQ + DW;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [AW-1:0]      rd_sel;
  logic [DW-1:0]      rd_data;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [PW-1:0]      dbg_ptr;

  regfile_read_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .addr    (addr),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  logic [DW-1:0] regs [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end
  assign rd_data = regs[rd_sel];

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ack_cycle", 64'(cyc), 64'(e[W-1 -: 16]));
        check_eq("ack_vec", 64'(ack), 64'(e[DW +: NREQ]));
        check_eq("rdata", 64'(rdata), 64'(e[DW-1:0]));
      end
    end else if (exp_q.size() > 0 && exp_q[0][W-1 -: 16] < cyc) begin
      e = exp_q.pop_front();
      check_eq("ack_missing", 64'(ack), 64'(e[DW +: NREQ]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_reg(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic set_addr(input int i, input int a);
    addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic expect_ack(input int c, input int r, input logic [DW-1:0] d);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    exp_q.push_back({c[15:0], oh, d});
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    tick();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  int n;
  logic [DW-1:0] vals [NREQ];

  initial begin
    reset   = 1'b1;
    req     = '0;
    addr    = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    do_reset();

    check_eq("rst_ack", 64'(ack), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rd_sel", 64'(rd_sel), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_ptr", 64'(dbg_ptr), 64'd0);

    // Single read of register 7.
    write_reg(7, 32'hDEAD_BEEF);
    set_addr(0, 7);
    req = 4'b0001;
    n = int'(cyc);
    expect_ack(n + PIPE_LAT, 0, 32'hDEAD_BEEF);
    tick();
    check_eq("single_rd_sel", 64'(rd_sel), 64'd7);
    check_eq("single_busy", 64'(busy), 64'd1);
    check_eq("single_ptr", 64'(dbg_ptr), 64'd1);
    tick();
    req = '0;
    drain();
    check_eq("single_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

    // Contention: all four request at once, each reads register i+1.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      vals[i] = DW'($urandom_range(32'h7FFF_FFFF, 1));
      write_reg(i + 1, vals[i]);
      set_addr(i, i + 1);
    end
    req = 4'b1111;
    n = int'(cyc);
    for (int i = 0; i < NREQ; i++) expect_ack(n + PIPE_LAT + i, i, vals[i]);
    for (int k = 0; k < 8; k++) begin
      tick();
      req = req & ~ack;
    end
    drain();

    // Fairness: 0 and 2 held; 0 stays masked while its ack is pending.
    do_reset();
    write_reg(3, 32'h3333_0003);
    write_reg(5, 32'h5555_0005);
    set_addr(0, 3);
    set_addr(2, 5);
    req = 4'b0101;
    n = int'(cyc);
    expect_ack(n + 2, 0, 32'h3333_0003);
    expect_ack(n + 3, 2, 32'h5555_0005);
    expect_ack(n + 5, 0, 32'h3333_0003);
    expect_ack(n + 6, 2, 32'h5555_0005);
    repeat (5) tick();
    req = '0;
    drain();

    // Idle: nothing moves, rd_sel and ptr keep their last values.
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("idle_ack", 64'(ack), 64'd0);
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_rd_sel", 64'(rd_sel), 64'd5);
      check_eq("idle_ptr", 64'(dbg_ptr), 64'd3);
    end

    // Forwarding: same-address write in the read cycle is returned.
    do_reset();
    write_reg(9, 32'h1);
    set_addr(0, 9);
    req = 4'b0001;
    n = int'(cyc);
    expect_ack(n + PIPE_LAT, 0, 32'h55);
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    req   = '0;
    drain();

    // Different-address write in the read cycle must not be forwarded.
    write_reg(9, 32'h1);
    req = 4'b0001;
    n = int'(cyc);
    expect_ack(n + PIPE_LAT, 0, 32'h1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    req   = '0;
    drain();

    // Reset while a grant is in flight: no ack ever appears.
    do_reset();
    write_reg(7, 32'h77);
    set_addr(0, 7);
    req = 4'b0001;
    tick();
    check_eq("midrst_busy_before", 64'(busy), 64'd1);
    check_eq("midrst_ptr_before", 64'(dbg_ptr), 64'd1);
    reset = 1'b1;
    req   = '0;
    tick();
    check_eq("midrst_ack", 64'(ack), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ptr", 64'(dbg_ptr), 64'd0);
    reset = 1'b0;
    tick();
    tick();
    check_eq("midrst_ack_after", 64'(ack), 64'd0);
    check_eq("midrst_busy_after", 64'(busy), 64'd0);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
